// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard unit: forward selects,
// FSM state encoding and counter widths.
package hazard_pkg;

    localparam int unsigned RAW_DEFAULT = 5;
    localparam int unsigned FWD_W       = 2;
    localparam int unsigned CNT_W       = 2;
    localparam int unsigned PCNT_W      = 4;

    localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    typedef logic [0:0] state_t;
    localparam state_t RUN   = 1'b0;
    localparam state_t STALL = 1'b1;

endpackage

// File: rtl/hazard_unit_fwd_cmp.sv
// Single forwarding/hazard comparator: hit when a write-enabled, non-zero
// destination register matches a source register.
module fwd_cmp
    import hazard_pkg::*;
#(
    parameter int unsigned RAW = RAW_DEFAULT
) (
    input  logic [RAW-1:0] dst,
    input  logic           regwrite_n,
    input  logic [RAW-1:0] src,
    output logic           hit
);

    assign hit = !regwrite_n && (dst != '0) && (dst == src);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: EX/ID/MEM forwarding selects, load-use and branch
// stalls, and an optional multiply scoreboard enabled by HAZARD_MULDIV_EN.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned RAW     = RAW_DEFAULT,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [RAW-1:0] id_rs,
    input  logic [RAW-1:0] id_rt,
    input  logic [RAW-1:0] ex_rs,
    input  logic [RAW-1:0] ex_rt,
    input  logic [RAW-1:0] ex_dst,
    input  logic [RAW-1:0] mem_dst,
    input  logic [RAW-1:0] wb_dst,
    input  logic           ex_regwrite_n,
    input  logic           mem_regwrite_n,
    input  logic           wb_regwrite_n,
    input  logic           ex_memread,
    input  logic           id_branch,
    input  logic           id_mul,
    input  logic           ex_mul,
    output logic [1:0]     fwd_a,
    output logic [1:0]     fwd_b,
    output logic           fwd_id_a,
    output logic           fwd_id_b,
    output logic           fwd_mem,
    output logic           stall,
    output logic           bubble
);

    logic mem_a_hit, mem_b_hit, wb_a_hit, wb_b_hit;
    logic ex_ida_hit, ex_idb_hit;

    fwd_cmp #(.RAW(RAW)) u_mem_a  (.dst(mem_dst), .regwrite_n(mem_regwrite_n), .src(ex_rs),   .hit(mem_a_hit));
    fwd_cmp #(.RAW(RAW)) u_mem_b  (.dst(mem_dst), .regwrite_n(mem_regwrite_n), .src(ex_rt),   .hit(mem_b_hit));
    fwd_cmp #(.RAW(RAW)) u_wb_a   (.dst(wb_dst),  .regwrite_n(wb_regwrite_n),  .src(ex_rs),   .hit(wb_a_hit));
    fwd_cmp #(.RAW(RAW)) u_wb_b   (.dst(wb_dst),  .regwrite_n(wb_regwrite_n),  .src(ex_rt),   .hit(wb_b_hit));
    fwd_cmp #(.RAW(RAW)) u_mem_ia (.dst(mem_dst), .regwrite_n(mem_regwrite_n), .src(id_rs),   .hit(fwd_id_a));
    fwd_cmp #(.RAW(RAW)) u_mem_ib (.dst(mem_dst), .regwrite_n(mem_regwrite_n), .src(id_rt),   .hit(fwd_id_b));
    fwd_cmp #(.RAW(RAW)) u_wb_mem (.dst(wb_dst),  .regwrite_n(wb_regwrite_n),  .src(mem_dst), .hit(fwd_mem));
    fwd_cmp #(.RAW(RAW)) u_ex_ia  (.dst(ex_dst),  .regwrite_n(ex_regwrite_n),  .src(id_rs),   .hit(ex_ida_hit));
    fwd_cmp #(.RAW(RAW)) u_ex_ib  (.dst(ex_dst),  .regwrite_n(ex_regwrite_n),  .src(id_rt),   .hit(ex_idb_hit));

    // EX operand selects: the younger MEM result wins over WB.
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (mem_a_hit)     fwd_a = FWD_MEM;
        else if (wb_a_hit) fwd_a = FWD_WB;
        if (mem_b_hit)     fwd_b = FWD_MEM;
        else if (wb_b_hit) fwd_b = FWD_WB;
    end

    logic ex_id_hit, hz_load, hz_branch;

    assign ex_id_hit = ex_ida_hit || ex_idb_hit;
    assign hz_load   = ex_memread && ex_id_hit;
    assign hz_branch = id_branch && !ex_memread && ex_id_hit;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fsm_stall;

    // A load feeding a branch needs the extra STALL cycle; all others stall once.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fsm_stall = 1'b0;
        case (state_q)
            RUN: begin
                if (hz_load || hz_branch) begin
                    fsm_stall = 1'b1;
                end
                if (hz_load && id_branch) begin
                    cnt_d   = CNT_W'(1);
                    state_d = STALL;
                end
            end
            STALL: begin
                fsm_stall = 1'b1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic mul_stall;

`ifdef HAZARD_MULDIV_EN
    logic              pend_valid_q, pend_valid_d;
    logic [PCNT_W-1:0] pend_cnt_q, pend_cnt_d;
    logic [RAW-1:0]    pend_dst_q, pend_dst_d;

    // Countdown of the in-flight multiply; a fresh issue overrides expiry.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_cnt_d   = pend_cnt_q;
        pend_dst_d   = pend_dst_q;
        if (pend_valid_q) begin
            if (pend_cnt_q <= PCNT_W'(1)) begin
                pend_valid_d = 1'b0;
                pend_cnt_d   = '0;
            end else begin
                pend_cnt_d = pend_cnt_q - PCNT_W'(1);
            end
        end
        if (ex_mul && !ex_regwrite_n && (ex_dst != '0)) begin
            pend_valid_d = 1'b1;
            pend_dst_d   = ex_dst;
            pend_cnt_d   = PCNT_W'(MUL_LAT - 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_cnt_q   <= '0;
            pend_dst_q   <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_cnt_q   <= pend_cnt_d;
            pend_dst_q   <= pend_dst_d;
        end
    end

    assign mul_stall = pend_valid_q &&
                       ((id_rs == pend_dst_q) || (id_rt == pend_dst_q) || id_mul);
`else
    logic unused_mul;

    assign unused_mul = ^{id_mul, ex_mul, PCNT_W'(MUL_LAT)};
    assign mul_stall  = 1'b0;
`endif

    assign stall  = !rst && (fsm_stall || mul_stall);
    assign bubble = stall;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; multiply scoreboard
// scenarios are exercised when HAZARD_MULDIV_EN is defined.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
    logic       ex_regwrite_n, mem_regwrite_n, wb_regwrite_n;
    logic       ex_memread, id_branch, id_mul, ex_mul;
    logic [1:0] fwd_a, fwd_b;
    logic       fwd_id_a, fwd_id_b, fwd_mem, stall, bubble;

    int checks   = 0;
    int failures = 0;

    hazard_unit #(.RAW(5), .MUL_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
        .ex_regwrite_n(ex_regwrite_n), .mem_regwrite_n(mem_regwrite_n),
        .wb_regwrite_n(wb_regwrite_n), .ex_memread(ex_memread),
        .id_branch(id_branch), .id_mul(id_mul), .ex_mul(ex_mul),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b),
        .fwd_mem(fwd_mem), .stall(stall), .bubble(bubble)
    );

    always #5 clk = ~clk;

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0;
        ex_dst = 0; mem_dst = 0; wb_dst = 0;
        ex_regwrite_n = 1; mem_regwrite_n = 1; wb_regwrite_n = 1;
        ex_memread = 0; id_branch = 0; id_mul = 0; ex_mul = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        idle();
        ex_memread = 1; ex_dst = 5; ex_regwrite_n = 0; id_rt = 5;
        #1;
        checks++;
        if ({stall, bubble} !== 2'b00) begin
            failures++; $display("FAIL reset_stall got=%b exp=00", {stall, bubble});
        end
        checks++;
        if ({fwd_a, fwd_b, fwd_id_a, fwd_id_b, fwd_mem} !== 7'd0) begin
            failures++; $display("FAIL reset_fwd got=%b exp=0", {fwd_a, fwd_b, fwd_id_a, fwd_id_b, fwd_mem});
        end
        @(negedge clk);
        idle();
        rst = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL reset_release got=%b exp=0", stall);
        end
    endtask

    task automatic test_fwd_ex();
        @(negedge clk);
        idle();
        ex_dst = 3; mem_dst = 3; wb_dst = 3;
        ex_regwrite_n = 0; mem_regwrite_n = 0; wb_regwrite_n = 0;
        ex_rs = 3; ex_rt = 3;
        #1;
        checks++;
        if (fwd_a !== 2'b10) begin
            failures++; $display("FAIL fwd_a_mem_prio got=%b exp=10", fwd_a);
        end
        checks++;
        if (fwd_b !== 2'b10) begin
            failures++; $display("FAIL fwd_b_mem_prio got=%b exp=10", fwd_b);
        end
        mem_regwrite_n = 1;
        #1;
        checks++;
        if (fwd_a !== 2'b01) begin
            failures++; $display("FAIL fwd_a_mem_nowrite got=%b exp=01", fwd_a);
        end
        mem_regwrite_n = 0; mem_dst = 0;
        #1;
        checks++;
        if (fwd_a !== 2'b01) begin
            failures++; $display("FAIL fwd_a_mem_dst0 got=%b exp=01", fwd_a);
        end
        wb_regwrite_n = 1; ex_rt = 4;
        #1;
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            failures++; $display("FAIL fwd_ab_none got=%b exp=0000", {fwd_a, fwd_b});
        end
    endtask

    task automatic test_fwd_id_mem();
        @(negedge clk);
        idle();
        mem_dst = 4; mem_regwrite_n = 0; id_rs = 4; id_rt = 6;
        #1;
        checks++;
        if ({fwd_id_a, fwd_id_b} !== 2'b10) begin
            failures++; $display("FAIL fwd_id_rs got=%b exp=10", {fwd_id_a, fwd_id_b});
        end
        id_rs = 6; id_rt = 4;
        #1;
        checks++;
        if ({fwd_id_a, fwd_id_b} !== 2'b01) begin
            failures++; $display("FAIL fwd_id_rt got=%b exp=01", {fwd_id_a, fwd_id_b});
        end
        idle();
        wb_dst = 9; mem_dst = 9; wb_regwrite_n = 0;
        #1;
        checks++;
        if (fwd_mem !== 1'b1) begin
            failures++; $display("FAIL fwd_mem_hit got=%b exp=1", fwd_mem);
        end
        wb_regwrite_n = 1;
        #1;
        checks++;
        if (fwd_mem !== 1'b0) begin
            failures++; $display("FAIL fwd_mem_nowrite got=%b exp=0", fwd_mem);
        end
        idle();
        ex_regwrite_n = 0; mem_regwrite_n = 0; wb_regwrite_n = 0;
        #1;
        checks++;
        if ({fwd_a, fwd_b, fwd_id_a, fwd_id_b, fwd_mem, stall, bubble} !== 9'd0) begin
            failures++; $display("FAIL all_zero got=%b exp=0", {fwd_a, fwd_b, fwd_id_a, fwd_id_b, fwd_mem, stall, bubble});
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        idle();
        ex_memread = 1; ex_dst = 5; ex_regwrite_n = 0; id_rt = 5;
        mem_dst = 2; mem_regwrite_n = 0; ex_rs = 2;
        #1;
        checks++;
        if ({stall, bubble} !== 2'b11) begin
            failures++; $display("FAIL lu_c0 got=%b exp=11", {stall, bubble});
        end
        checks++;
        if (fwd_a !== 2'b10) begin
            failures++; $display("FAIL lu_fwd_during_stall got=%b exp=10", fwd_a);
        end
        @(negedge clk);
        ex_memread = 0; ex_dst = 0; ex_regwrite_n = 1;
        #1;
        checks++;
        if ({stall, bubble} !== 2'b00) begin
            failures++; $display("FAIL lu_c1 got=%b exp=00", {stall, bubble});
        end
        @(negedge clk);
        idle();
        ex_memread = 1; ex_dst = 5; ex_regwrite_n = 0; id_rt = 5; id_branch = 1;
        #1;
        checks++;
        if ({stall, bubble} !== 2'b11) begin
            failures++; $display("FAIL lubr_c0 got=%b exp=11", {stall, bubble});
        end
        @(negedge clk);
        ex_memread = 0; ex_dst = 0; ex_regwrite_n = 1;
        #1;
        checks++;
        if ({stall, bubble} !== 2'b11) begin
            failures++; $display("FAIL lubr_c1 got=%b exp=11", {stall, bubble});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({stall, bubble} !== 2'b00) begin
            failures++; $display("FAIL lubr_c2 got=%b exp=00", {stall, bubble});
        end
    endtask

    task automatic test_branch_alu();
        @(negedge clk);
        idle();
        id_branch = 1; ex_dst = 6; ex_regwrite_n = 0; id_rs = 6;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++; $display("FAIL bralu_c0 got=%b exp=1", stall);
        end
        @(negedge clk);
        ex_dst = 0; ex_regwrite_n = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL bralu_c1 got=%b exp=0", stall);
        end
        ex_dst = 6;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL bralu_nowrite got=%b exp=0", stall);
        end
    endtask

    task automatic test_mul();
        logic [3:0] exp_v;
        logic [3:0] got_v;
        for (int variant = 0; variant < 2; variant++) begin
            @(negedge clk);
            idle();
            ex_mul = 1; ex_dst = 7; ex_regwrite_n = 0;
            #1;
            checks++;
            if (stall !== 1'b0) begin
                failures++; $display("FAIL mul_issue v=%0d got=%b exp=0", variant, stall);
            end
`ifdef HAZARD_MULDIV_EN
            exp_v = 4'b1110;
`else
            exp_v = 4'b0000;
`endif
            got_v = 4'b0000;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                idle();
                if (variant == 0) id_rs = 7;
                else id_mul = 1;
                #1;
                got_v[3-c] = stall;
            end
            checks++;
            if (got_v !== exp_v) begin
                failures++; $display("FAIL mul_stall_seq v=%0d got=%b exp=%b", variant, got_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle();
        ex_memread = 1; ex_dst = 5; ex_regwrite_n = 0; id_rt = 5; id_branch = 1;
        @(negedge clk);
        ex_memread = 0; ex_dst = 0; ex_regwrite_n = 1;
        #1;
        rst = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL rst_in_stall got=%b exp=0", stall);
        end
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL rst_stall_after got=%b exp=0", stall);
        end
        @(negedge clk);
        idle();
        ex_mul = 1; ex_dst = 7; ex_regwrite_n = 0;
        @(negedge clk);
        idle();
        id_rs = 7;
        #1;
        rst = 1;
        #1;
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL rst_mul_after got=%b exp=0", stall);
        end
`ifdef HAZARD_MULDIV_EN
        checks++;
        if (dut.pend_valid_q !== 1'b0) begin
            failures++; $display("FAIL rst_pend_valid got=%b exp=0", dut.pend_valid_q);
        end
`endif
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_fwd_ex();
        test_fwd_id_mem();
        test_load_use();
        test_branch_alu();
        test_mul();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter RAW, default 5, register-address width.
REQ-002 SHALL have parameter MUL_LAT, default 4, legal range 2..15, multi-cycle multiply result latency in cycles.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-005 SHALL have ports id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst, input, RAW bits each, stage source and destination register numbers.
REQ-006 SHALL have ports ex_regwrite_n, mem_regwrite_n, wb_regwrite_n, input, 1 bit each; active-low, 0 means the stage writes its destination.
REQ-007 SHALL have ports ex_memread, id_branch, id_mul, ex_mul, input, 1 bit each: EX is a load, ID is a branch, ID is a multiply, EX issues a multiply.
REQ-008 SHALL have ports fwd_a and fwd_b, output, 2 bits each, EX operand select: 00 register file, 01 WB, 10 MEM.
REQ-009 SHALL have ports fwd_id_a, fwd_id_b, fwd_mem, output, 1 bit each, ID branch-compare forward from MEM and WB-to-MEM store-data forward.
REQ-010 SHALL have ports stall and bubble, output, 1 bit each: hold PC and IF/ID, and zero the ID/EX control.

Function
REQ-011 SHALL never forward when the matching destination is 0 or its regwrite_n is 1.
REQ-012 SHALL compute fwd_a and fwd_b combinationally, giving MEM priority (10) over WB (01) when both match.
REQ-013 SHALL assert fwd_id_a or fwd_id_b when a writing mem_dst matches id_rs or id_rt, and fwd_mem when a writing wb_dst equals mem_dst.
REQ-014 SHALL detect, in state RUN and combinationally, a load-use hazard: ex_memread=1, writing ex_dst!=0, and ex_dst matching id_rs or id_rt; stall length is 1, or 2 if id_branch=1.
REQ-015 SHALL detect a branch-ALU hazard: id_branch=1, ex_memread=0, and writing ex_dst matching id_rs or id_rt; stall length is 1.
REQ-016 SHALL assert stall and bubble in the detection cycle and, if the length is 2, load cnt with 1 and go to STALL.
REQ-017 SHALL, in STALL, hold stall and bubble at 1, decrement cnt, ignore new detections, and return to RUN after the cycle in which cnt=1.
REQ-018 SHALL keep the FSM states RUN and STALL only, with a 2-bit cnt.
REQ-019 SHALL set pend_valid=1, pend_dst=ex_dst and pend_cnt=MUL_LAT-1 on ex_mul=1 with a writing ex_dst!=0.
REQ-020 SHALL decrement pend_cnt every cycle while pend_valid=1 and clear pend_valid when it reaches 0.
REQ-021 SHALL assert stall and bubble while pend_valid=1 and either id_rs or id_rt equals pend_dst, or id_mul=1 (structural hazard).
REQ-022 SHALL OR all stall sources; a stall cycle SHALL NOT alter fwd_* outputs.
REQ-023 SHALL let a new ex_mul that coincides with pend_cnt reaching 0 win, reloading the pending entry.

Reset
REQ-024 SHALL on rst force state RUN, cnt=0, pend_valid=0, pend_cnt=0, pend_dst=0; stall and bubble read 0 during reset.
REQ-025 SHALL have fwd_* depend only on inputs, so they are 0 whenever no write-enabled match exists, reset included.
REQ-026 SHALL abort a STALL or pending multiply immediately when rst is asserted mid-operation, with no residual stall after release.

Configuration
REQ-027 SHALL compile the multiply scoreboard (REQ-019..023) only when HAZARD_MULDIV_EN is defined.
REQ-028 SHALL, without HAZARD_MULDIV_EN, ignore id_mul and ex_mul, remove pend_* registers, and leave all other behaviour unchanged.

Structure
REQ-029 SHALL place in shared package hazard_pkg the fwd select constants FWD_REG=00, FWD_WB=01, FWD_MEM=10, the FSM state typedef (RUN, STALL) and the default RAW.
REQ-030 SHALL implement each forwarding match as instances of sub-module fwd_cmp (dst, regwrite_n, src -> hit).

Verification
REQ-031 SHALL cover: ex_dst=3 writing, mem_dst=3 writing, wb_dst=3 writing, ex_rs=3 -> fwd_a=10; with mem_regwrite_n=1 -> fwd_a=01; with mem_dst=0 -> fwd_a=01.
REQ-032 SHALL cover: ex_memread=1, ex_dst=5, id_rt=5, id_branch=0 -> stall=bubble=1 exactly 1 cycle; with id_branch=1 -> exactly 2 cycles.
REQ-033 SHALL cover, with HAZARD_MULDIV_EN and MUL_LAT=4: ex_mul with ex_dst=7, next cycle id_rs=7 -> stall=1 for 3 cycles, then 0; with id_mul=1 instead -> same stall.
REQ-034 SHALL cover: rst pulsed during the second STALL cycle and during pending multiply -> stall=0 in the cycle after release, pend_valid=0.
REQ-035 SHALL cover: wb_dst=9 writing, mem_dst=9 -> fwd_mem=1; wb_regwrite_n=1 -> fwd_mem=0; all-zero addresses -> all outputs 0.
